// File: rtl/bus_master.sv
// Purpose : initiator end of the system bus; decodes the slave from addr[12:11], runs one bus cycle and returns the slave's response.
// Latency : accept edge E0 -> m_valid the cycle after E0 -> resp_valid the cycle after the slave's sl_valid; decode error -> resp_valid the cycle after E0.
// Backpress: one transaction outstanding; req_ready is high only in IDLE, and requests are held off until the response pulse has been sent.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   req_valid/req_ready/req_mode/req_addr/req_wdata   request from the local requester (mode 1 = write)
//   resp_valid/resp_rdata/resp_err      single-cycle response; rdata/err hold until the next response
//   mode/addr/wdata/m_valid/sl_select   bus outputs toward the slaves (sl_select is one-hot)
//   sl_valid/rdata                      per-slave completion pulse and read data (slave i at [8i+7:8i])
//
// Optional feature macro: BUS_MASTER_TIMEOUT_EN. When it is defined, WAIT gives up after TIMEOUT cycles
// and returns an error. When it is undefined, WAIT lasts until sl_valid or reset.
module bus_master #(
   parameter int NUM_SLAVES = 3,
   parameter int TIMEOUT    = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_mode,
   input  logic [15:0]               req_addr,
   input  logic [7:0]                req_wdata,
   output logic                      resp_valid,
   output logic [7:0]                resp_rdata,
   output logic                      resp_err,
   output logic                      mode,
   output logic [15:0]               addr,
   output logic [7:0]                wdata,
   output logic                      m_valid,
   output logic [NUM_SLAVES-1:0]     sl_select,
   input  logic [NUM_SLAVES-1:0]     sl_valid,
   input  logic [8*NUM_SLAVES-1:0]   rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic            mode_q, mode_d;
   logic [15:0]     addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      resp_rdata_q, resp_rdata_d;
   logic            resp_err_q, resp_err_d;

   // Signals belonging to the currently selected slave.
   logic                  sel_vld;
   logic [7:0]            sel_rdata;
   logic [NUM_SLAVES-1:0] sel_onehot;
   logic                  addr_ok;

`ifdef BUS_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Slaves that do not exist are never matched. A bad index therefore selects nothing.
   always_comb begin
      sel_vld    = 1'b0;
      sel_rdata  = '0;
      sel_onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == 2'(i)) begin
            sel_vld       = sl_valid[i];
            sel_rdata     = rdata[8*i +: 8];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   assign addr_ok = (req_addr[15:13] == 3'b000) && (32'(req_addr[12:11]) < NUM_SLAVES);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mode_d       = mode_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
`ifdef BUS_MASTER_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               mode_d  = req_mode;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               idx_d   = req_addr[12:11];
               if (addr_ok) begin
                  state_d = REQ;
               end else begin
                  // No bus cycle is run. The error response comes out directly.
                  state_d      = RESP;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 8'h00;
               end
            end
         end
         REQ: begin
            state_d = WAIT;
`ifdef BUS_MASTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            // If sl_valid and timeout expiry happen in the same cycle, sl_valid wins.
            if (sel_vld) begin
               state_d      = RESP;
               resp_err_d   = 1'b0;
               resp_rdata_d = mode_q ? 8'h00 : sel_rdata;
            end
`ifdef BUS_MASTER_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d      = RESP;
               resp_err_d   = 1'b1;
               resp_rdata_d = 8'h00;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         mode_q       <= 1'b0;
         addr_q       <= 16'h0000;
         wdata_q      <= 8'h00;
         resp_rdata_q <= 8'h00;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mode_q       <= mode_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

`ifdef BUS_MASTER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign req_ready  = (state_q == IDLE);
   assign m_valid    = (state_q == REQ);
   assign sl_select  = ((state_q == REQ) || (state_q == WAIT)) ? sel_onehot : '0;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mode       = mode_q;
   assign addr       = addr_q;
   assign wdata      = wdata_q;

endmodule

// File: tb/tb_bus_master.sv
// Purpose : self-checking bench for bus_master with a simple slave model and a response scoreboard.
// Latency : slaves answer with sl_valid four edges after they sample m_valid.
// Backpress: requests are held until req_ready; each response is awaited with a bounded wait.
module tb_bus_master;
   localparam int NS = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req_valid, req_ready, req_mode;
   logic [15:0]     req_addr;
   logic [7:0]      req_wdata;
   logic            resp_valid, resp_err;
   logic [7:0]      resp_rdata;
   logic            mode, m_valid;
   logic [15:0]     addr;
   logic [7:0]      wdata;
   logic [NS-1:0]   sl_select, sl_valid;
   logic [8*NS-1:0] rdata;

   bus_master #(.NUM_SLAVES(NS), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mode(mode), .addr(addr), .wdata(wdata), .m_valid(m_valid),
      .sl_select(sl_select), .sl_valid(sl_valid), .rdata(rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- slave model ----------------
   logic [7:0] mem [0:NS-1][0:255];
   bit         mute = 1'b0;
   logic [NS-1:0] extra_vld = '0;
   int         pend_cnt = -1;
   int         pend_idx = 0;
   logic [7:0] pend_dat;

   always begin
      @(posedge clk); #1;
      sl_valid  = extra_vld;
      extra_vld = '0;
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            sl_valid[pend_idx]       = 1'b1;
            rdata[pend_idx*8 +: 8]   = pend_dat;
            pend_cnt                 = -1;
         end
      end
      if (m_valid && !mute) begin
         for (int i = 0; i < NS; i++) if (sl_select[i]) pend_idx = i;
         rdata = 24'($urandom);
         if (mode) begin
            mem[pend_idx][addr[7:0]] = wdata;
            pend_dat = 8'($urandom);
         end else begin
            pend_dat = mem[pend_idx][addr[7:0]];
         end
         pend_cnt = 4;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      logic [7:0] rd;
      logic       err;
      int         lat;
      int         acc;
   } exp_t;
   exp_t          sb[$];
   logic [NS-1:0] sel_q[$];
   int            mv_count = 0;
   bit            mv_prev = 0;
   logic [NS-1:0] mv_sel;
   bit            ready_next = 0;

   always @(negedge clk) begin
      if (ready_next) begin
         check("req_ready_after_resp", req_ready, 1);
         ready_next = 0;
      end
      if (mv_prev) begin
         check("m_valid_one_cycle", m_valid, 0);
         check("sl_select_held", sl_select, mv_sel);
         mv_prev = 0;
      end
      if (m_valid) begin
         mv_count++;
         if (sel_q.size() == 0) begin
            check("m_valid_unexpected", m_valid, 0);
         end else begin
            mv_sel = sel_q.pop_front();
            check("sl_select", sl_select, mv_sel);
            mv_prev = 1;
         end
      end
      if (resp_valid) begin
         if (sb.size() == 0) begin
            check("resp_unexpected", resp_valid, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_rdata", resp_rdata, e.rd);
            check("resp_err", resp_err, e.err);
            check("resp_latency", cyc - e.acc, e.lat);
            check("sl_select_in_resp", sl_select, 0);
            check("req_ready_in_resp", req_ready, 0);
            ready_next = 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_req(input logic m, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] er, input logic ee, input int lat,
                         input bit bus, input bit track);
      int n = 0;
      logic [NS-1:0] oh;
      req_mode = m; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("req_ready_wait", req_ready, 1);
      if (track) sb.push_back('{er, ee, lat, cyc + 1});
      if (bus) begin
         oh = '0;
         oh[a[12:11]] = 1'b1;
         sel_q.push_back(oh);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk); n++;
      end
      check("resp_arrived", sb.size(), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk); #1;
      end
   endtask

   int mv_before;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_addr = '0; req_wdata = '0;
      sl_valid = '0; rdata = '0;
      for (int s = 0; s < NS; s++) for (int j = 0; j < 256; j++) mem[s][j] = 8'h00;
      idle_cycles(2);
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_sl_select", sl_select, 0);
      check("rst_addr", addr, 0);
      rst_n = 1'b1;
      idle_cycles(1);

      // slave 0 write then read
      do_req(1'b1, 16'h0123, 8'h5A, 8'h00, 1'b0, 5, 1, 1); wait_done();
      do_req(1'b0, 16'h0123, 8'h00, 8'h5A, 1'b0, 5, 1, 1); wait_done();

      // slaves 1 and 2
      do_req(1'b1, 16'h0801, 8'hC3, 8'h00, 1'b0, 5, 1, 1); wait_done();
      do_req(1'b1, 16'h1001, 8'h3C, 8'h00, 1'b0, 5, 1, 1); wait_done();
      do_req(1'b0, 16'h0801, 8'h00, 8'hC3, 1'b0, 5, 1, 1); wait_done();
      do_req(1'b0, 16'h1001, 8'h00, 8'h3C, 1'b0, 5, 1, 1); wait_done();

      // decode errors: no bus cycle
      mv_before = mv_count;
      do_req(1'b0, 16'h1800, 8'h00, 8'h00, 1'b1, 0, 0, 1); wait_done();
      do_req(1'b1, 16'h2000, 8'h77, 8'h00, 1'b1, 0, 0, 1); wait_done();
      check("decode_err_no_m_valid", mv_count - mv_before, 0);

      // spurious sl_valid[0] while waiting on slave 1
      do_req(1'b0, 16'h0801, 8'h00, 8'hC3, 1'b0, 5, 1, 1);
      idle_cycles(1);
      extra_vld = 3'b001;
      wait_done();

      // late sl_valid pulses while idle
      extra_vld = 3'b111;
      idle_cycles(4);
      check("idle_ready", req_ready, 1);

`ifdef BUS_MASTER_TIMEOUT_EN
      mute = 1'b1;
      do_req(1'b0, 16'h0123, 8'h00, 8'h00, 1'b1, 16, 1, 1); wait_done();
      mute = 1'b0;
`endif

      // reset during WAIT
      mute = 1'b1;
      do_req(1'b0, 16'h0801, 8'h00, 8'h00, 1'b0, 0, 1, 0);
      idle_cycles(2);
      rst_n = 1'b0;
      idle_cycles(1);
      check("midrst_req_ready", req_ready, 1);
      check("midrst_m_valid", m_valid, 0);
      check("midrst_sl_select", sl_select, 0);
      check("midrst_resp_valid", resp_valid, 0);
      check("midrst_addr", addr, 0);
      check("midrst_mode", mode, 0);
      check("midrst_resp_rdata", resp_rdata, 0);
      rst_n = 1'b1;
      mute  = 1'b0;
      idle_cycles(4);
      do_req(1'b0, 16'h0123, 8'h00, 8'h5A, 1'b0, 5, 1, 1); wait_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
